// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: accepts a word, shifts it out MSB first through a
// 5-bit history window, and counts occurrences of a loadable 5-bit pattern.
module seq_detect_ctrl #(
    parameter int         WORD_W  = 8,
    parameter int         CNT_W   = 8,
    parameter logic [4:0] RST_PAT = 5'b10110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pat_load,
    input  logic [4:0]        pat,
    input  logic              clr_count,
    output logic              bit_out,
    output logic              hit,
    output logic [CNT_W-1:0]  hit_count,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx_q;
    logic [4:0]         window_q, window_d;
    logic [2:0]         fill_q, fill_d;
    logic [4:0]         pattern_q;
    logic               hit_q;
    logic [CNT_W-1:0]   count_q;
    logic               shift_bit;
    logic               accept;
    logic               load;
    logic               match;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_bit = word_q[idx_q];
        window_d  = {window_q[3:0], shift_bit};
        fill_d    = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
        accept    = 1'b0;
        load      = 1'b0;
        match     = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bit_out   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                load     = pat_load;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                bit_out = shift_bit;
                match   = (fill_d == 3'd5) && (window_d == pattern_q);
                if (idx_q == '0) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset wins on the outputs too, so they read as idle while rst is low.
        if (!rst) begin
            in_ready = 1'b1;
            busy     = 1'b0;
            done     = 1'b0;
            bit_out  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q <= RST_PAT;
            window_q  <= '0;
            fill_q    <= '0;
            hit_q     <= 1'b0;
            count_q   <= '0;
            word_q    <= '0;
            idx_q     <= '0;
        end else begin
            hit_q <= match;

            if (accept) begin
                word_q <= in_data;
                idx_q  <= IDX_W'(WORD_W - 1);
            end else if (state_q == SHIFT) begin
                idx_q <= idx_q - 1'b1;
            end

            // Loading a pattern restarts history so old bits cannot match the new pattern.
            if (load) begin
                pattern_q <= pat;
                window_q  <= '0;
                fill_q    <= '0;
            end else if (state_q == SHIFT) begin
                window_q <= window_d;
                fill_q   <= fill_d;
            end

            if (clr_count)
                count_q <= '0;
            else if (match && (count_q != '1))
                count_q <= count_q + 1'b1;
        end
    end

    assign hit       = hit_q & rst;
    assign hit_count = count_q;

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter WORD_W, default 8, SHALL set the input word width in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the hit counter width in bits.
REQ-003 Parameter RST_PAT, default 5'b10110, SHALL set the detection pattern held after reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate in_data holds a word to scan.
REQ-007 in_data  input  WORD_W  SHALL carry the word to scan, MSB first.
REQ-008 in_ready  output  1  SHALL indicate a word can be accepted this cycle.
REQ-009 pat_load  input  1  SHALL request loading pat into the pattern register.
REQ-010 pat  input  5  SHALL carry the new 5-bit pattern; the first-received bit is pat[4].
REQ-011 clr_count  input  1  SHALL request clearing hit_count.
REQ-012 bit_out  output  1  SHALL carry the bit being shifted this cycle.
REQ-013 hit  output  1  SHALL pulse once per detected pattern occurrence.
REQ-014 hit_count  output  CNT_W  SHALL report the number of hits since the last reset or clear.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-016 done  output  1  SHALL pulse for one cycle when a word finishes scanning.

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 IDLE: in_ready=1; when in_valid=1, the block SHALL latch in_data, set bit index to WORD_W-1, and go to SHIFT.
REQ-019 SHIFT: each cycle, the block SHALL drive bit_out with word[index], shift that bit into a 5-bit history window, and decrement the index; after index 0 it SHALL go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then the FSM SHALL go to IDLE; one word therefore occupies WORD_W+1 cycles.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE, so no word is accepted there; bit_out SHALL be 0 outside SHIFT.
REQ-022 The window and its fill count (0..5, saturating at 5) SHALL persist across words, so matches spanning a word boundary are detected.
REQ-023 A match SHALL occur when, after a shift, fill=5 and the window equals the pattern; overlapping matches SHALL count.
REQ-024 hit SHALL be registered: high only in the cycle after the shift that completed a match, low otherwise.
REQ-025 hit_count SHALL increment on the same edge that sets hit, and SHALL saturate at 2^CNT_W-1.
REQ-026 clr_count SHALL set hit_count to 0, and SHALL take priority over a simultaneous increment.
REQ-027 pat_load SHALL be honoured only in IDLE; when honoured it SHALL load pat and clear the window and fill count. In SHIFT or DONE it SHALL be ignored.
REQ-028 When pat_load and in_valid are both high in IDLE, the block SHALL load the pattern and accept the word in the same cycle; that word SHALL be scanned against the new pattern.

Reset
REQ-029 With rst=0 at a rising edge, the block SHALL set: state=IDLE, pattern=RST_PAT, window=0, fill=0, hit_count=0.
REQ-030 During and after that edge, outputs SHALL be: in_ready=1, busy=0, done=0, hit=0, bit_out=0.
REQ-031 Reset SHALL override all other inputs, including a reset asserted mid-SHIFT; no done pulse SHALL follow an aborted word.

Verification
REQ-032 Reset check: hold rst=0 for 1 cycle -> in_ready=1, busy=0, hit=0, hit_count=0.
REQ-033 Default pattern, overlap: send in_data=8'b10110110 -> hit pulses after bits 5 and 8, hit_count=2, done pulses 9 cycles after acceptance.
REQ-034 Cross-word match: send 8'b00000010 then 8'b11000000 -> exactly one hit, which pulses after the 3rd bit of the second word; hit_count=1.
REQ-035 Pattern load: pat_load with pat=5'b11111 mid-SHIFT -> ignored, pattern stays 10110. Then pat_load in IDLE plus 8'hFF -> hits after bits 5 to 8, hit_count=4.
REQ-036 Counter limits: with hit_count=255 a further hit leaves it at 255. clr_count coincident with a hit -> hit_count=0.
REQ-037 Reset mid-word: rst=0 in the 4th SHIFT cycle -> next cycle state=IDLE, in_ready=1, done never pulses, fill=0.
